// File: rtl/uart_block_rx.sv
// 8N1 UART receiver that packs BLOCK_BYTES bytes (first byte at the MSB end) into one block with valid/ready.
// Optional inter-byte idle timeout is built when UART_BLOCK_RX_TIMEOUT_EN is defined.
module uart_block_rx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 115200,
  parameter int BLOCK_BYTES  = 16,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       uart_rx,
  output logic [0:8*BLOCK_BYTES-1]   o_block,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_frame_err,
  output logic                       o_overrun,
  output logic                       o_timeout,
  output logic                       o_busy
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                   state_reg, state_next;
  logic [1:0]               sync_reg;
  logic                     rx_sync;
  logic [CNT_W-1:0]         cnt_reg, cnt_next;
  logic [2:0]               bit_reg, bit_next;
  logic [7:0]               shift_reg, shift_next;
  logic                     armed_reg, armed_next;
  logic [IDX_W-1:0]         idx_reg, idx_next;
  logic [0:8*BLOCK_BYTES-1] block_reg, block_cat;
  logic                     valid_reg, valid_next;
  logic                     frame_err_reg, overrun_reg;
  logic                     start_det, byte_accept, frame_err;
  logic                     complete, load, overrun, timeout_hit;
  logic [7:0]               buf_reg [BLOCK_BYTES-1];

  assign rx_sync = sync_reg[1];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    armed_next  = armed_reg | rx_sync;
    start_det   = 1'b0;
    byte_accept = 1'b0;
    frame_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !rx_sync) begin
          start_det  = 1'b1;
          cnt_next   = CNT_HALF;
          state_next = START;
        end
      end
      START: begin
        if (cnt_reg == '0) begin
          if (!rx_sync) begin
            state_next = DATA;
            cnt_next   = CNT_FULL;
            bit_next   = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
          shift_next = {rx_sync, shift_reg[7:1]};
          cnt_next   = CNT_FULL;
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          if (rx_sync) begin
            byte_accept = 1'b1;
          end else begin
            // Line is still low here; wait for it to go high before hunting for a start bit.
            frame_err  = 1'b1;
            armed_next = 1'b0;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    complete   = byte_accept && (idx_reg == IDX_LAST);
    load       = complete && (!valid_reg || i_ready);
    overrun    = complete && valid_reg && !i_ready;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    if (frame_err || timeout_hit) idx_next = '0;
    else if (byte_accept)         idx_next = complete ? '0 : idx_reg + IDX_W'(1);
    if (load)                     valid_next = 1'b1;
    else if (valid_reg && i_ready) valid_next = 1'b0;
  end

  // The final byte is taken straight from the shifter so the block loads on the stop-sample edge.
  genvar gi;
  generate
    for (gi = 0; gi < BLOCK_BYTES - 1; gi++) begin : g_slot
      assign block_cat[8*gi +: 8] = buf_reg[gi];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       buf_reg[gi] <= '0;
        else if (byte_accept && idx_reg == IDX_W'(gi))    buf_reg[gi] <= shift_reg;
      end
    end
  endgenerate
  assign block_cat[8*(BLOCK_BYTES-1) +: 8] = shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg      <= 2'b11;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      armed_reg     <= 1'b1;
      idx_reg       <= '0;
      block_reg     <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], uart_rx};
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      armed_reg     <= armed_next;
      idx_reg       <= idx_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err;
      overrun_reg   <= overrun;
      if (load) block_reg <= block_cat;
    end
  end

`ifdef UART_BLOCK_RX_TIMEOUT_EN
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS * DIV);
  logic [31:0] idle_cnt_reg;
  logic        timeout_reg;

  assign timeout_hit = (state_reg == IDLE) && (idx_reg != '0) && !start_det &&
                       (idle_cnt_reg == TO_LIMIT - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= timeout_hit;
      if (state_reg != IDLE || idx_reg == '0 || start_det || timeout_hit)
        idle_cnt_reg <= '0;
      else
        idle_cnt_reg <= idle_cnt_reg + 32'd1;
    end
  end
  assign o_timeout = timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  assign o_block     = block_reg;
  assign o_valid     = valid_reg;
  assign o_frame_err = frame_err_reg;
  assign o_overrun   = overrun_reg;
  assign o_busy      = (state_reg != IDLE) || (idx_reg != '0);

endmodule

// File: tb/tb_uart_block_rx.sv
// Scoreboard bench for uart_block_rx: blocks queued at send time, compared when the consumer takes them.
module tb_uart_block_rx;

  localparam int DIV = 16;
  localparam int LAT = 3 + DIV / 2 + 9 * DIV;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         uart_rx;
  logic [0:127] o_block;
  logic         o_valid;
  logic         i_ready;
  logic         o_frame_err, o_overrun, o_timeout, o_busy;

  uart_block_rx #(.CLK_FREQ(1600000), .BAUD(100000), .BLOCK_BYTES(16), .TIMEOUT_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .o_block(o_block), .o_valid(o_valid),
    .i_ready(i_ready), .o_frame_err(o_frame_err), .o_overrun(o_overrun),
    .o_timeout(o_timeout), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  int fe_cnt, ov_cnt, to_cnt, valid_cycles, valid_rise_cyc, last_start;
  logic prev_valid = 1'b0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_blk;

  // Monitor: pulse counters and scoreboard pop on every accepted block.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (o_frame_err) fe_cnt++;
      if (o_overrun) ov_cnt++;
      if (o_timeout) to_cnt++;
      if (o_valid) valid_cycles++;
      if (o_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = o_valid;
      if (o_valid && i_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: unexpected block %h, required none", o_block);
        end else begin
          exp_blk = exp_q.pop_front();
          if (o_block !== exp_blk) begin
            n_fail++;
            $display("FAIL scoreboard: block %h, required %h", o_block, exp_blk);
          end else begin
            $display("block %h consumed at cycle %0d", o_block, cyc);
          end
        end
      end
    end
  end

  task automatic clear_counts();
    fe_cnt = 0; ov_cnt = 0; to_cnt = 0; valid_cycles = 0; valid_rise_cyc = 0;
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(posedge clk); #1;
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(!bad_stop);
    if (bad_stop) drive_bit(1'b1);
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wait_done: %0d blocks outstanding after %0d cycles, required 0", exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; uart_rx = 1'b1; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_valid, o_frame_err, o_overrun, o_timeout, o_busy} !== 5'b0 || o_block !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/fe/ov/to/busy=%b block=%h, required 0", 
               {o_valid, o_frame_err, o_overrun, o_timeout, o_busy}, o_block);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b valid=%b, required 0 0", o_busy, o_valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_block();
    logic [7:0] fb [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                            8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};
    clear_counts();
    i_ready = 1'b1;
    exp_q.push_back(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int i = 0; i < 16; i++) send_byte(fb[i], 1'b0);
    wait_done(4 * DIV);
    n_checks++;
    if (valid_rise_cyc - last_start != LAT) begin
      n_fail++;
      $display("FAIL full_latency: %0d cycles, required %0d", valid_rise_cyc - last_start, LAT);
    end
    n_checks++;
    if (valid_cycles != 1) begin
      n_fail++;
      $display("FAIL full_valid_width: %0d cycles, required 1", valid_cycles);
    end
    n_checks++;
    if (fe_cnt + ov_cnt + to_cnt != 0) begin
      n_fail++;
      $display("FAIL full_no_errors: fe=%0d ov=%0d to=%0d, required 0", fe_cnt, ov_cnt, to_cnt);
    end
    $display("test_full_block done");
  endtask

  task automatic test_glitch();
    clear_counts();
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (DIV / 2 - 2) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start_seen: busy=%b, required 1", o_busy);
    end
    @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || valid_cycles != 0 || fe_cnt != 0) begin
      n_fail++;
      $display("FAIL glitch_reject: busy=%b valid_cycles=%0d fe=%0d, required 0 0 0", o_busy, valid_cycles, fe_cnt);
    end
    $display("test_glitch done");
  endtask

  task automatic test_frame_err();
    clear_counts();
    i_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'(i), 1'b0);
    send_byte(8'h05, 1'b1);
    exp_q.push_back(128'h000102030405060708090a0b0c0d0e0f);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    wait_done(4 * DIV);
    n_checks++;
    if (fe_cnt != 1 || valid_cycles != 1) begin
      n_fail++;
      $display("FAIL frame_err: pulses=%0d blocks=%0d, required 1 1", fe_cnt, valid_cycles);
    end
    $display("test_frame_err done");
  endtask

  task automatic test_backpressure();
    logic [127:0] blk_a, blk_b;
    clear_counts();
    i_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      blk_a[32*i +: 32] = $urandom;
      blk_b[32*i +: 32] = $urandom;
    end
    exp_q.push_back(blk_a);
    for (int i = 15; i >= 0; i--) send_byte(blk_a[8*i +: 8], 1'b0);
    for (int i = 15; i >= 0; i--) send_byte(blk_b[8*i +: 8], 1'b0);
    repeat (DIV) @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b1 || o_block !== blk_a) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b block=%h, required 1 %h", o_valid, o_block, blk_a);
    end
    n_checks++;
    if (ov_cnt != 1) begin
      n_fail++;
      $display("FAIL bp_overrun: pulses=%0d, required 1", ov_cnt);
    end
    @(posedge clk); #1;
    i_ready = 1'b1;
    wait_done(4);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b, required 0", o_valid);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    clear_counts();
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'h5c, 1'b0);
    @(posedge clk); #1;
    uart_rx = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #1;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy: busy=%b, required 1", o_busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_clear: busy=%b valid=%b, required 0 0", o_busy, o_valid);
    end
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    exp_q.push_back({16{8'h11}});
    for (int i = 0; i < 16; i++) send_byte(8'h11, 1'b0);
    wait_done(4 * DIV);
    $display("test_reset_mid done");
  endtask

  task automatic test_timeout();
    clear_counts();
    i_ready = 1'b1;
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b0);
    repeat (33 * DIV) @(posedge clk);
    #1;
`ifdef UART_BLOCK_RX_TIMEOUT_EN
    exp_q.push_back({16{8'haa}});
`else
    exp_q.push_back({8'h01, 8'h02, 8'h03, {13{8'haa}}});
`endif
    for (int i = 0; i < 16; i++) send_byte(8'haa, 1'b0);
    wait_done(4 * DIV);
    n_checks++;
`ifdef UART_BLOCK_RX_TIMEOUT_EN
    if (to_cnt != 1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: pulses=%0d busy=%b, required 1 0", to_cnt, o_busy);
    end
`else
    if (to_cnt != 0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: pulses=%0d busy=%b, required 0 1", to_cnt, o_busy);
    end
`endif
    $display("test_timeout done");
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_full_block();
    test_glitch();
    test_frame_err();
    test_backpressure();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
